alu_181_seq: RTL and testbench
==============================

Name: alu_181_seq

Overview:
- Parametrised, multi-cycle successor to the 4-bit 181-style ALU slice.
- Applies the 181 function set (S[3:0], M, active-low carry) to WIDTH-bit operands.
- Processes SLICES_PER_CYCLE 4-bit slices per clock and registers the carry between steps, so wide operands cost cycles rather than a long combinational chain.
- Sits between operand registers and the result bus, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and >= 4.
- SLICES_PER_CYCLE, 1, 4-bit slices evaluated per RUN cycle; must divide WIDTH/4. Derived STEPS = WIDTH/(4*SLICES_PER_CYCLE).
- A parameter violating either rule is an elaboration error.

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/command valid
- in_ready  out  1  block can accept a command (high only in IDLE)
- s  in  4  181 function select
- m  in  1  1 = logic mode, 0 = arithmetic mode
- cin_n  in  1  active-low carry-in to the least significant slice
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer accepts the result
- y  out  WIDTH  result
- cout_n  out  1  active-low carry-out of the most significant slice
- aeqb  out  1  1 when every bit of y is 1 (181 A=B output semantics)

Behaviour:
- Function set is per-slice identical to the 181 with active-high data:
  - M=1 gives logic functions; the carry does not affect y.
  - M=0 gives arithmetic; a carry enters the next slice when the previous slice's cout_n = 0.
  - Required points: S=1001 M=0 is A plus B (cin_n=0 adds 1); S=0110 M=0 is A minus B minus 1 (cin_n=0 gives A minus B); S=0110 M=1 is A xor B; S=1011 M=1 is A and B; S=1110 M=1 is A or B; S=0000 M=1 is not A.
- Carry chain uses slice generate/propagate only and is independent of M. cout_n is therefore reported in logic mode too.
- State machine IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid=1, latch a, b, s, m and cin_n into internal registers, clear the step counter, load the carry register from cin_n, and go to RUN.
  - RUN: each cycle evaluates slices [k*SPC .. k*SPC+SPC-1] using the registered carry, writes those bits into an internal accumulator, updates the carry register, and increments k. Inputs are ignored.
  - RUN exit: on the cycle with k = STEPS-1, copy accumulator to y, carry to cout_n, compute aeqb from the final result, and go to DONE.
  - DONE: out_valid=1. y, cout_n and aeqb are held stable. On out_ready=1, go to IDLE.
- Latency: out_valid rises STEPS cycles after the accepting edge. Example: WIDTH=16, SPC=1 gives 4 cycles; SPC=4 gives 1 cycle.
- Throughput: one command per STEPS+2 cycles minimum. No same-cycle accept-on-drain; in_ready rises the cycle after the out handshake.
- y, cout_n and aeqb change only on entry to DONE and on reset. Between results they hold the last result.
- Inputs changing during RUN or DONE have no effect on the result in flight.
- Reset (any state, including mid-RUN or mid-DONE) returns the block to IDLE and aborts any operation with no output. Reset values: in_ready=1, out_valid=0, y=0, cout_n=1, aeqb=0; internal counter, carry register and accumulator are cleared.
- Carry wrap: the carry out of the top slice is only reported; it is never fed back.

Test Plan:
- Add, WIDTH=16, SPC=1: S=1001, M=0, cin_n=1, a=0x1234, b=0x0FFF -> y=0x2233, cout_n=1, aeqb=0; out_valid high exactly 4 cycles after the accept edge.
- Subtract: S=0110, M=0, cin_n=0, a=0x0005, b=0x0007 -> y=0xFFFE, cout_n=1. Repeat with a=0x0007, b=0x0005 -> y=0x0002, cout_n=0.
- Equality: S=0110, M=0, cin_n=1, a=b=0xABCD -> y=0xFFFF, aeqb=1, cout_n=1.
- Logic xor: S=0110, M=1, a=0xF0F0, b=0xFF00, with cin_n=0 and then cin_n=1 -> y=0x0FF0 in both cases.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, while toggling in_valid, a and b -> y, cout_n and aeqb stay stable, in_ready=0, no second command accepted. Release out_ready -> in_ready=1 on the next cycle.
- Reset and config:
  - Assert rst during RUN step 2 -> next cycle in_ready=1, out_valid=0, y=0, cout_n=1.
  - Rerun the add case with SPC=4 -> same result with 1-cycle latency.

Source files
------------

// File: rtl/alu_181_seq.sv
// alu_181_seq: multi-cycle 181-style ALU. Applies the 181 function set to WIDTH-bit
// operands, SLICES_PER_CYCLE 4-bit slices per clock, with the inter-slice carry held
// in a register between steps. Valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for a command; in_ready high, operands latched on in_valid
// RUN   | one group of slices evaluated per cycle, carry registered between groups
// DONE  | result held on y/cout_n/aeqb with out_valid high until out_ready

module alu_181_seq #(
  parameter int WIDTH            = 16,
  parameter int SLICES_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout_n,
  output logic             aeqb
);

  localparam int NSLICE   = WIDTH / 4;
  localparam int SPC_SAFE = (SLICES_PER_CYCLE > 0) ? SLICES_PER_CYCLE : 1;
  localparam int STEPS    = ((NSLICE / SPC_SAFE) > 0) ? (NSLICE / SPC_SAFE) : 1;
  localparam int CHUNK    = 4 * SPC_SAFE;
  localparam int KW       = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [KW-1:0]    K_LAST     = KW'(STEPS - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = ~({WIDTH{1'b1}} << CHUNK);

  // Reject illegal configurations at elaboration time.
  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("alu_181_seq: WIDTH must be a multiple of 4 and at least 4");
  end
  if ((SLICES_PER_CYCLE < 1) || ((NSLICE % SPC_SAFE) != 0)) begin : g_bad_spc
    $error("alu_181_seq: SLICES_PER_CYCLE must divide WIDTH/4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;     // active-high carry into the current group
  logic [KW-1:0]    k_q;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_chunk, b_chunk, f_chunk;
  logic [WIDTH-1:0] chunk_ext, acc_next;
  logic             carry_next, last_step;

  // per-slice temporaries of the evaluation loop
  logic [3:0] px, gy, fs;
  logic       ci, sg, sp, c;

  assign shamt     = 32'(CHUNK) * 32'(k_q);
  assign a_chunk   = CHUNK'(a_q >> shamt);
  assign b_chunk   = CHUNK'(b_q >> shamt);
  assign last_step = (k_q == K_LAST);

  // Evaluate the current group of slices. Per bit, px is the OR-type term and gy the
  // AND-type term of the 181; gy implies px, so gy is the bit generate and px the bit
  // propagate. Logic mode is the inverted half-sum and ignores the carry; the carry
  // chain itself never looks at m.
  always_comb begin
    px         = '0;
    gy         = '0;
    fs         = '0;
    ci         = 1'b0;
    sg         = 1'b0;
    sp         = 1'b0;
    c          = carry_q;
    f_chunk    = '0;
    for (int j = 0; j < SPC_SAFE; j++) begin
      px = a_chunk[4*j +: 4] | (b_chunk[4*j +: 4] & {4{s_q[0]}})
         | (~b_chunk[4*j +: 4] & {4{s_q[1]}});
      gy = (a_chunk[4*j +: 4] & b_chunk[4*j +: 4] & {4{s_q[3]}})
         | (a_chunk[4*j +: 4] & ~b_chunk[4*j +: 4] & {4{s_q[2]}});
      ci = c;
      for (int i = 0; i < 4; i++) begin
        fs[i] = m_q ? ~(px[i] ^ gy[i]) : (px[i] ^ gy[i] ^ ci);
        ci    = gy[i] | (px[i] & ci);
      end
      f_chunk[4*j +: 4] = fs;
      // slice-level generate/propagate drives the carry into the next slice
      sg = gy[3] | (px[3] & gy[2]) | (px[3] & px[2] & gy[1])
         | (px[3] & px[2] & px[1] & gy[0]);
      sp = &px;
      c  = sg | (sp & c);
    end
    carry_next = c;
  end

  assign chunk_ext = WIDTH'(f_chunk);
  assign acc_next  = (acc_q & ~(CHUNK_MASK << shamt)) | (chunk_ext << shamt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_step) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, step counter, carry/accumulator update and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      k_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      y       <= '0;
      cout_n  <= 1'b1;
      aeqb    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            k_q     <= '0;
            carry_q <= ~cin_n;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_next;
          carry_q <= carry_next;
          k_q     <= k_q + KW'(1);
          if (last_step) begin
            y      <= acc_next;
            cout_n <= ~carry_next;
            aeqb   <= &acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_181_seq.sv
// tb_alu_181_seq: drives an SPC=1 and an SPC=4 instance with shared stimulus and checks
// both every cycle against a transaction-level model built from the 181 function table.

module tb_alu_181_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, m, cin_n;
  logic [3:0]   s;
  logic [W-1:0] a, b;

  logic         in_ready0, out_valid0, cout_n0, aeqb0;
  logic [W-1:0] y0;
  logic         in_ready1, out_valid1, cout_n1, aeqb1;
  logic [W-1:0] y1;

  alu_181_seq #(.WIDTH(W), .SLICES_PER_CYCLE(1)) u_spc1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .s(s), .m(m), .cin_n(cin_n), .a(a), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready),
    .y(y0), .cout_n(cout_n0), .aeqb(aeqb0)
  );

  alu_181_seq #(.WIDTH(W), .SLICES_PER_CYCLE(4)) u_spc4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .s(s), .m(m), .cin_n(cin_n), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready),
    .y(y1), .cout_n(cout_n1), .aeqb(aeqb1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic column of the 181 table (active-high data), W+1 bits so the top bit is the carry.
  function automatic logic [W:0] ref_arith(input logic [3:0] fs, input logic [W-1:0] x,
                                           input logic [W-1:0] z, input logic cin);
    logic [W:0] av, bv, nb, ones, r;
    av   = {1'b0, x};
    bv   = {1'b0, z};
    nb   = {1'b0, ~z};
    ones = {1'b0, {W{1'b1}}};
    case (fs)
      4'h0: r = av;
      4'h1: r = av | bv;
      4'h2: r = av | nb;
      4'h3: r = ones;
      4'h4: r = av + (av & nb);
      4'h5: r = (av | bv) + (av & nb);
      4'h6: r = av + nb;
      4'h7: r = (av & nb) + ones;
      4'h8: r = av + (av & bv);
      4'h9: r = av + bv;
      4'hA: r = (av | nb) + (av & bv);
      4'hB: r = (av & bv) + ones;
      4'hC: r = av + av;
      4'hD: r = (av | bv) + av;
      4'hE: r = (av | nb) + av;
      default: r = av + ones;
    endcase
    return r + {{W{1'b0}}, cin};
  endfunction

  // Logic column of the 181 table (active-high data).
  function automatic logic [W-1:0] ref_logic(input logic [3:0] fs, input logic [W-1:0] x,
                                             input logic [W-1:0] z);
    case (fs)
      4'h0: return ~x;
      4'h1: return ~(x | z);
      4'h2: return ~x & z;
      4'h3: return '0;
      4'h4: return ~(x & z);
      4'h5: return ~z;
      4'h6: return x ^ z;
      4'h7: return x & ~z;
      4'h8: return ~x | z;
      4'h9: return ~(x ^ z);
      4'hA: return z;
      4'hB: return x & z;
      4'hC: return '1;
      4'hD: return x | ~z;
      4'hE: return x | z;
      default: return x;
    endcase
  endfunction

  // {aeqb, cout_n, y}
  function automatic logic [W+1:0] ref_op(input logic [3:0] fs, input logic fm, input logic fcn,
                                          input logic [W-1:0] x, input logic [W-1:0] z);
    logic [W:0]   r;
    logic [W-1:0] yv;
    r  = ref_arith(fs, x, z, ~fcn);
    yv = fm ? ref_logic(fs, x, z) : r[W-1:0];
    return {&yv, ~r[W], yv};
  endfunction

  // Transaction model: 0 idle, 1 busy for STEPS cycles, 2 result presented.
  int           steps_n [2] = '{4, 1};
  int           ph      [2];
  int           left    [2];
  logic [W+1:0] pend    [2];
  logic [W+1:0] held    [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i]   <= 0;
        left[i] <= 0;
        held[i] <= {1'b0, 1'b1, {W{1'b0}}};
      end else begin
        case (ph[i])
          0: if (in_valid) begin
            pend[i] <= ref_op(s, m, cin_n, a, b);
            left[i] <= steps_n[i];
            ph[i]   <= 1;
          end
          1: begin
            left[i] <= left[i] - 1;
            if (left[i] == 1) begin
              ph[i]   <= 2;
              held[i] <= pend[i];
            end
          end
          default: if (out_ready) ph[i] <= 0;
        endcase
      end
    end
  end

  task automatic cmp_dut(input int i, input string tag, input logic ir, input logic ov,
                         input logic [W-1:0] yy, input logic cc, input logic ee);
    chk({tag, " in_ready"},  32'(ir), 32'(ph[i] == 0));
    chk({tag, " out_valid"}, 32'(ov), 32'(ph[i] == 2));
    chk({tag, " y"},         32'(yy), 32'(held[i][W-1:0]));
    chk({tag, " cout_n"},    32'(cc), 32'(held[i][W]));
    chk({tag, " aeqb"},      32'(ee), 32'(held[i][W+1]));
  endtask

  logic chk_en = 1'b0;

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, "spc1", in_ready0, out_valid0, y0, cout_n0, aeqb0);
      cmp_dut(1, "spc4", in_ready1, out_valid1, y1, cout_n1, aeqb1);
    end
  end

  // Directed op with literal expectations; called #1 after a clock edge with both idle.
  task automatic run_op(input string nm, input logic [3:0] fs, input logic fm, input logic fcn,
                        input logic [W-1:0] fa, input logic [W-1:0] fb,
                        input logic [W-1:0] ey, input logic ec, input logic ee);
    logic [W+1:0] r;
    int lat0, lat1;
    r = ref_op(fs, fm, fcn, fa, fb);
    chk({nm, " model y"},      32'(r[W-1:0]), 32'(ey));
    chk({nm, " model cout_n"}, 32'(r[W]),     32'(ec));
    chk({nm, " model aeqb"},   32'(r[W+1]),   32'(ee));
    s = fs; m = fm; cin_n = fcn; a = fa; b = fb;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); s = 4'($urandom); m = 1'($urandom); cin_n = 1'($urandom);
    lat0 = -1; lat1 = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (lat0 < 0 && out_valid0) lat0 = n;
      if (lat1 < 0 && out_valid1) lat1 = n;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
    chk({nm, " spc1 latency"}, 32'(lat0), 32'(4));
    chk({nm, " spc4 latency"}, 32'(lat1), 32'(1));
    chk({nm, " spc1 y"},      32'(y0),      32'(ey));
    chk({nm, " spc4 y"},      32'(y1),      32'(ey));
    chk({nm, " spc1 cout_n"}, 32'(cout_n0), 32'(ec));
    chk({nm, " spc4 cout_n"}, 32'(cout_n1), 32'(ec));
    chk({nm, " spc1 aeqb"},   32'(aeqb0),   32'(ee));
    chk({nm, " spc4 aeqb"},   32'(aeqb1),   32'(ee));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    s = '0; m = 1'b0; cin_n = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset spc1 in_ready", 32'(in_ready0), 32'(1));
    chk("reset spc1 y",        32'(y0),        32'(0));
    chk("reset spc4 cout_n",   32'(cout_n1),   32'(1));

    run_op("add",      4'h9, 1'b0, 1'b1, 16'h1234, 16'h0FFF, 16'h2233, 1'b1, 1'b0);
    run_op("sub 5-7",  4'h6, 1'b0, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0);
    run_op("sub 7-5",  4'h6, 1'b0, 1'b0, 16'h0007, 16'h0005, 16'h0002, 1'b0, 1'b0);
    run_op("equal",    4'h6, 1'b0, 1'b1, 16'hABCD, 16'hABCD, 16'hFFFF, 1'b1, 1'b1);
    run_op("xor c0",   4'h6, 1'b1, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b1, 1'b0);
    run_op("xor c1",   4'h6, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b1, 1'b0);
    run_op("and",      4'hB, 1'b1, 1'b1, 16'hC3A5, 16'h0FF0, 16'h03A0, 1'b0, 1'b0);
    run_op("or",       4'hE, 1'b1, 1'b1, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0);
    run_op("not a",    4'h0, 1'b1, 1'b1, 16'h00FF, 16'h1111, 16'hFF00, 1'b1, 1'b0);
    run_op("ones",     4'hC, 1'b1, 1'b1, 16'h8000, 16'h1234, 16'hFFFF, 1'b0, 1'b1);
    run_op("wrap add", 4'h9, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
    run_op("cin ripple", 4'h9, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Backpressure: result held, no accept while out_ready stays low.
    s = 4'h9; m = 1'b0; cin_n = 1'b1; a = 16'h1234; b = 16'h0FFF;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 20 && !(out_valid0 && out_valid1); n++) begin
      @(posedge clk); #1;
    end
    for (int n = 0; n < 10; n++) begin
      in_valid = ~in_valid; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("bp spc1 y",        32'(y0),        32'(16'h2233));
      chk("bp spc4 y",        32'(y1),        32'(16'h2233));
      chk("bp spc1 in_ready", 32'(in_ready0), 32'(0));
      chk("bp spc4 in_ready", 32'(in_ready1), 32'(0));
      chk("bp spc1 out_valid", 32'(out_valid0), 32'(1));
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release spc1 in_ready",  32'(in_ready0),  32'(1));
    chk("bp release spc4 in_ready",  32'(in_ready1),  32'(1));
    chk("bp release spc1 out_valid", 32'(out_valid0), 32'(0));
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset while the SPC=1 instance is mid-RUN.
    s = 4'h9; m = 1'b0; cin_n = 1'b1; a = 16'h1234; b = 16'h0FFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid-run reset spc1 in_ready",  32'(in_ready0),  32'(1));
    chk("mid-run reset spc1 out_valid", 32'(out_valid0), 32'(0));
    chk("mid-run reset spc1 y",         32'(y0),         32'(0));
    chk("mid-run reset spc1 cout_n",    32'(cout_n0),    32'(1));
    chk("mid-run reset spc4 out_valid", 32'(out_valid1), 32'(0));
    chk("mid-run reset spc4 y",         32'(y1),         32'(0));
    run_op("add again", 4'h9, 1'b0, 1'b1, 16'h1234, 16'h0FFF, 16'h2233, 1'b1, 1'b0);

    // Random traffic including occasional resets; the negedge process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      s         = 4'($urandom);
      m         = 1'($urandom);
      cin_n     = 1'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
